// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU operation codes and the main-decoder-to-ALU-decoder aluop.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the main decoder's aluop and the R-type funct field to
// the 3-bit alucontrol; purely combinational.
module alu_dec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback. Define MC_CTRL_BNE_EN to add bne support (BNEEX state).
module mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t     state_q, state_d;
  logic       pcwrite, branch, branchne;
  logic [1:0] aluop;
  logic       op_known;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state_dbg = state_q;

  always_comb begin
    op_known = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
`ifdef MC_CTRL_BNE_EN
      OP_BNE: op_known = 1'b1;
`endif
      default: op_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH:   begin irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
      S_DECODE:  begin alusrcb = 2'b11; illegal_op = ~op_known; end
      S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB:   begin regwrite = 1'b1; memtoreg = 1'b1; end
      S_MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      S_RTYPEEX: begin alusrca = 1'b1; aluop = ALUOP_FUNCT; end
      S_RTYPEWB: begin regwrite = 1'b1; regdst = 1'b1; end
      S_BEQEX:   begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; branch = 1'b1; end
      S_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_ADDIWB:  regwrite = 1'b1;
      S_JEX:     begin pcwrite = 1'b1; pcsrc = 2'b10; end
`ifdef MC_CTRL_BNE_EN
      S_BNEEX:   begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; branchne = 1'b1; end
`endif
      default:   ;
    endcase
    // Reset overrides whatever state is held: no strobes, FETCH mux selects.
    if (reset) begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branchne   = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b01;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      pcsrc      = 2'b00;
      aluop      = ALUOP_ADD;
      illegal_op = 1'b0;
    end
  end

  assign pcen = pcwrite | (branch & zero) | (branchne & ~zero);

  alu_dec u_alu_dec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
